// File: rtl/local_pred_update_queue.sv
// local_pred_update_queue
//   In-order resolution queue on the write side of the local 3-bit counter
//   table. Each fetch-time local prediction {index, taken} is recorded; when
//   the oldest branch resolves, its entry retires and a registered update
//   (index, actual outcome, mispredict flag) is driven to the counter table.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   pred_valid/ready  push handshake; pred_ready = not full
//   pred_index/taken  table index and predicted direction to record
//   resolve_valid/ready  pop handshake; resolve_ready = not empty
//   resolve_taken     actual outcome of the oldest branch
//   flush             drop all in-flight entries (wins over push/pop)
//   upd_valid/index/taken  registered counter-table update, 1 cycle after pop
//   mispredict        pulses with upd_valid when outcome != recorded prediction
//   count             current occupancy
//   miss_count        (LPUQ_STATS_EN only) saturating 16-bit mispredict count
//
// Build option: define LPUQ_STATS_EN to add the miss_count output.

module local_pred_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDXW  = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [IDXW-1:0]          pred_index,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    input  logic                     flush,
    output logic                     upd_valid,
    output logic [IDXW-1:0]          upd_index,
    output logic                     upd_taken,
    output logic                     mispredict,
`ifdef LPUQ_STATS_EN
    output logic [15:0]              miss_count,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Entry storage is never reset: flush/reset only invalidate via pointers.
    logic [IDXW-1:0] idx_mem [DEPTH];
    logic            tkn_mem [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            upd_valid_q, upd_valid_d;
    logic [IDXW-1:0] upd_index_q, upd_index_d;
    logic            upd_taken_q, upd_taken_d;
    logic            mispredict_q, mispredict_d;

    logic push, pop;

    // Ready signals come only from registered occupancy.
    assign pred_ready    = (count_q != FULL);
    assign resolve_ready = (count_q != '0);

    assign push = pred_valid    && pred_ready    && !flush;
    assign pop  = resolve_valid && resolve_ready && !flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        upd_valid_d  = pop;
        upd_index_d  = upd_index_q;
        upd_taken_d  = upd_taken_q;
        mispredict_d = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;   // DEPTH is 2^AW, wraps naturally
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                upd_index_d  = idx_mem[rd_ptr_q];
                upd_taken_d  = resolve_taken;
                mispredict_d = (resolve_taken != tkn_mem[rd_ptr_q]);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            idx_mem[wr_ptr_q] <= pred_index;
            tkn_mem[wr_ptr_q] <= pred_taken;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            upd_valid_q  <= 1'b0;
            upd_index_q  <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            upd_valid_q  <= upd_valid_d;
            upd_index_q  <= upd_index_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
        end
    end

`ifdef LPUQ_STATS_EN
    // Counts on the same edge that raises mispredict; survives flush.
    logic [15:0] miss_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            miss_count_q <= '0;
        else if (mispredict_d && miss_count_q != 16'hFFFF)
            miss_count_q <= miss_count_q + 16'd1;
    end

    assign miss_count = miss_count_q;
`endif

    assign upd_valid  = upd_valid_q;
    assign upd_index  = upd_index_q;
    assign upd_taken  = upd_taken_q;
    assign mispredict = mispredict_q;
    assign count      = count_q;

endmodule

// File: tb/tb_local_pred_update_queue.sv
// Directed bench for local_pred_update_queue (DEPTH=8, IDXW=10).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.

module tb_local_pred_update_queue;

    localparam int DEPTH = 8;
    localparam int IDXW  = 10;

    logic            clock, reset;
    logic            pred_valid, pred_taken, pred_ready;
    logic [IDXW-1:0] pred_index;
    logic            resolve_valid, resolve_taken, resolve_ready;
    logic            flush;
    logic            upd_valid, upd_taken, mispredict;
    logic [IDXW-1:0] upd_index;
    logic [3:0]      count;
`ifdef LPUQ_STATS_EN
    logic [15:0]     miss_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    local_pred_update_queue #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clock         (clock),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .pred_index    (pred_index),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_ready (resolve_ready),
        .flush         (flush),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
`ifdef LPUQ_STATS_EN
        .miss_count    (miss_count),
`endif
        .count         (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        pred_valid    = 1'b0;
        pred_index    = '0;
        pred_taken    = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
    endtask

    initial begin
        idle_in();
        reset = 1'b0;

        // Reset held 4 cycles
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_pred_ready",    pred_ready,    1);
            chk("rst_resolve_ready", resolve_ready, 0);
            chk("rst_count",         count,         0);
            chk("rst_upd_valid",     upd_valid,     0);
            chk("rst_upd_index",     upd_index,     0);
            chk("rst_mispredict",    mispredict,    0);
        end
        reset = 1'b1;
        step();
        chk("post_rst_upd_valid", upd_valid, 0);

        // Fill 0..7, then a 9th push that must be dropped
        for (int i = 0; i < 8; i++) begin
            pred_valid = 1'b1; pred_index = IDXW'(i); pred_taken = 1'b1;
            step();
            chk("fill_count", count, i + 1);
        end
        chk("full_pred_ready", pred_ready, 0);
        pred_index = 10'd8;
        step();
        chk("full_drop_count", count, 8);
        pred_valid = 1'b0;

        // Drain 8 in order
        for (int i = 0; i < 8; i++) begin
            resolve_valid = 1'b1; resolve_taken = 1'b1;
            step();
            chk("drain_upd_valid",  upd_valid,  1);
            chk("drain_upd_index",  upd_index,  i);
            chk("drain_upd_taken",  upd_taken,  1);
            chk("drain_mispredict", mispredict, 0);
            chk("drain_count",      count,      7 - i);
        end
        // Empty: resolve ignored, dropped 9th entry never appears
        step();
        chk("empty_upd_valid",     upd_valid,     0);
        chk("empty_count",         count,         0);
        chk("empty_resolve_ready", resolve_ready, 0);
        resolve_valid = 1'b0;

        // Mispredict: predicted not-taken, actually taken
        pred_valid = 1'b1; pred_index = 10'd5; pred_taken = 1'b0;
        step();
        pred_valid = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        chk("mp_upd_valid",  upd_valid,  1);
        chk("mp_upd_index",  upd_index,  5);
        chk("mp_upd_taken",  upd_taken,  1);
        chk("mp_mispredict", mispredict, 1);
`ifdef LPUQ_STATS_EN
        chk("mp_miss_count", miss_count, 1);
`endif
        resolve_valid = 1'b0;
        step();
        chk("mp_after_valid",      upd_valid,  0);
        chk("mp_after_mispredict", mispredict, 0);
        chk("mp_hold_index",       upd_index,  5);
        chk("mp_hold_taken",       upd_taken,  1);

        // Flush beats push and pop
        for (int i = 0; i < 3; i++) begin
            pred_valid = 1'b1; pred_index = IDXW'(10 + i); pred_taken = 1'b1;
            step();
        end
        chk("pre_flush_count", count, 3);
        pred_index = 10'd13; resolve_valid = 1'b1; resolve_taken = 1'b0; flush = 1'b1;
        step();
        idle_in();
        chk("flush_count",         count,         0);
        chk("flush_upd_valid",     upd_valid,     0);
        chk("flush_mispredict",    mispredict,    0);
        chk("flush_resolve_ready", resolve_ready, 0);
        chk("flush_hold_index",    upd_index,     5);

        // Steady push+pop across pointer wrap; entry i has taken = i[0]
        for (int i = 0; i < 3; i++) begin
            pred_valid = 1'b1; pred_index = IDXW'(100 + i); pred_taken = i[0];
            step();
        end
        for (int k = 0; k < 20; k++) begin
            pred_valid = 1'b1; pred_index = IDXW'(103 + k); pred_taken = k[0] ^ 1'b1;
            resolve_valid = 1'b1; resolve_taken = 1'b1;
            step();
            chk("wrap_count",      count,      3);
            chk("wrap_upd_valid",  upd_valid,  1);
            chk("wrap_upd_index",  upd_index,  100 + k);
            chk("wrap_mispredict", mispredict, (k % 2 == 0) ? 1 : 0);
        end
        // Top up to 4 entries (indices 120..123)
        resolve_valid = 1'b0;
        pred_index = 10'd123; pred_taken = 1'b1;
        step();
        pred_valid = 1'b0;
        chk("pre_rst_count", count, 4);

        // Asynchronous reset mid-stream, with a pop pending
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count",         count,         0);
        chk("arst_pred_ready",    pred_ready,    1);
        chk("arst_resolve_ready", resolve_ready, 0);
        chk("arst_upd_valid",     upd_valid,     0);
        chk("arst_upd_index",     upd_index,     0);
        chk("arst_upd_taken",     upd_taken,     0);
        chk("arst_mispredict",    mispredict,    0);
        step();
        chk("arst_hold_upd_valid", upd_valid, 0);
        idle_in();
        reset = 1'b1;
        step();

        // Only the new entry exists after reset
        pred_valid = 1'b1; pred_index = 10'd77; pred_taken = 1'b1;
        step();
        pred_valid = 1'b0;
        chk("new_count", count, 1);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        step();
        resolve_valid = 1'b0;
        chk("new_upd_valid",  upd_valid,  1);
        chk("new_upd_index",  upd_index,  77);
        chk("new_upd_taken",  upd_taken,  0);
        chk("new_mispredict", mispredict, 1);
        chk("new_count_end",  count,      0);
        step();
        chk("new_end_valid",  upd_valid,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/local_pred_update_queue.md
# local_pred_update_queue

In-order resolution queue that sits on the write side of the local 3-bit saturating counter table in the tournament predictor. It records each local prediction (table index plus predicted direction) at fetch time. When the branch resolves, it retires the oldest entry and drives the registered `BranchTaken` update toward the counter table. It also flags a mispredict when the actual outcome differs from the recorded prediction.

## Interface
Parameters:
- DEPTH, 8, number of in-flight predictions; power of two, ≥2
- IDXW, 10, width of the local counter table index

Ports:
- clock  input  1  sole clock, rising-edge
- reset  input  1  asynchronous, active-low; clears all state while low
- pred_valid  input  1  a new prediction is offered
- pred_index  input  IDXW  counter-table index of the predicted branch
- pred_taken  input  1  predicted direction (counter MSB at fetch)
- pred_ready  output  1  queue can accept; equals not-full
- resolve_valid  input  1  oldest branch has resolved
- resolve_taken  input  1  actual outcome of the oldest branch
- resolve_ready  output  1  an entry exists to retire; equals not-empty
- flush  input  1  discard all in-flight entries
- upd_valid  output  1  counter-table update strobe, one cycle per retire
- upd_index  output  IDXW  index to update
- upd_taken  output  1  BranchTaken value for the counter FSM
- mispredict  output  1  pulses with upd_valid when resolve_taken ≠ recorded pred_taken
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer of DEPTH entries {index, taken}, with write pointer, read pointer, and occupancy counter.
- Push fires when pred_valid && pred_ready. The entry is written at the write pointer, and the write pointer advances modulo DEPTH.
- Pop fires when resolve_valid && resolve_ready. The entry at the read pointer is retired, and the read pointer advances modulo DEPTH.
- On a pop, the following are registered:
  - upd_valid=1
  - upd_index=entry.index
  - upd_taken=resolve_taken
  - mispredict=(resolve_taken != entry.taken)
- On any cycle without a pop, upd_valid=0 and mispredict=0. upd_index and upd_taken hold their last values.
- Simultaneous push and pop with a non-empty, non-full queue: both are performed and count is unchanged.
- Full (count==DEPTH): pred_ready=0 and the push is dropped, even if a pop occurs in the same cycle. There is no same-cycle slot reuse.
- Empty (count==0): resolve_ready=0 and resolve_valid is ignored. A push and a resolve in the same cycle on an empty queue perform only the push; there is no bypass.
- Flush has priority over push and pop in the same cycle:
  - pointers and count return to 0
  - no update is emitted; upd_valid=0 and mispredict=0 that cycle
  - stored entries are not cleared, only invalidated
- Count arithmetic is exact. It never exceeds DEPTH and never underflows.

## Timing
- Reset values (reset low, asynchronous):
  - pointers=0, count=0
  - pred_ready=1, resolve_ready=0
  - upd_valid=0, upd_index=0, upd_taken=0, mispredict=0
- Reset asserted mid-operation discards all entries immediately. Any update that would have appeared on the next edge is suppressed.
- Update latency: the update outputs are valid in the cycle after the pop handshake edge (1 clock).
- pred_ready, resolve_ready and count are direct functions of registered state. They do not depend combinationally on the inputs in the same cycle.
- Back-to-back pops produce upd_valid high on consecutive cycles, in push order.

## Configuration
- LPUQ_STATS_EN defined:
  - adds output miss_count (16 bits), cleared by reset
  - increments on each mispredict pulse and saturates at 16'hFFFF
  - not cleared by flush
- LPUQ_STATS_EN undefined: the miss_count port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset held 4 cycles, then released: pred_ready=1, resolve_ready=0, count=0, upd_valid=0 throughout.
- Push indices 0..7 (pred_taken=1), then a 9th push: count=8, pred_ready=0, and the 9th entry is not stored. Then 8 resolves with taken=1: upd_index 0..7 in order, upd_taken=1, mispredict=0, count returns to 0.
- Push idx=5 with pred_taken=0, then resolve taken=1: next cycle upd_valid=1, upd_index=5, upd_taken=1, mispredict=1. With LPUQ_STATS_EN defined, miss_count=1.
- Fill with 3 entries, then assert push, resolve and flush together: count=0, upd_valid=0 next cycle, resolve_ready=0.
- Continuous push+resolve every cycle for 20 cycles across pointer wrap: count is constant, and each upd_index matches the index pushed count cycles earlier.
- Reset asserted mid-stream with 4 entries queued: all outputs take reset values immediately. After release, the first push/resolve retires only the new entry.
